// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - MIPS register file, 2 read ports, 1 write port, write counter
module banco_registradores #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [WIDTH-1:0] GP_INIT = 32'h0000_1800,
    parameter bit               BYPASS  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             regEscrita,
    input  logic [4:0]       enderecoEscrita,
    input  logic [WIDTH-1:0] dadoEscrita,
    input  logic [4:0]       enderecoLeitura1,
    input  logic [4:0]       enderecoLeitura2,
    output logic [WIDTH-1:0] dadoLeitura1,
    output logic [WIDTH-1:0] dadoLeitura2,
    input  logic [4:0]       enderecoDebug,
    output logic [WIDTH-1:0] dadoDebug,
    output logic [15:0]      contadorEscritas
);

    // Register 0 has no storage; only indices 1..31 hold state.
    logic [WIDTH-1:0] regs_q [31:1];
    logic [WIDTH-1:0] regs_d [31:1];
    logic [15:0]      contador_q;
    logic [15:0]      contador_d;

    // Zero-based view of the file with index 0 tied to zero, used by all read ports.
    logic [WIDTH-1:0] vista [32];

    logic escrita_efetiva;
    logic bypass1;
    logic bypass2;

    // Reset contents: everything zero except the stack and global pointers.
    function automatic logic [WIDTH-1:0] valor_reset(input int idx);
        if (idx == 28) begin
            return GP_INIT;
        end
        if (idx == 29) begin
            return SP_INIT;
        end
        return '0;
    endfunction

    // A write only takes effect for a nonzero destination; writes to $zero are dropped.
    assign escrita_efetiva = regEscrita && (enderecoEscrita != 5'd0);

    // Next-state of the register array: only the addressed register changes.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (escrita_efetiva && (enderecoEscrita == 5'(i))) begin
                regs_d[i] = dadoEscrita;
            end
        end
    end

    // Register array state; reset forces pointer init values and blocks any pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= valor_reset(i);
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Effective-write counter next-state, saturating rather than wrapping.
    always_comb begin
        contador_d = contador_q;
        if (escrita_efetiva && (contador_q != 16'hFFFF)) begin
            contador_d = contador_q + 16'd1;
        end
    end

    // Counter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_q <= 16'd0;
        end else begin
            contador_q <= contador_d;
        end
    end

    // Build the zero-based read view so index 0 always reads as zero.
    always_comb begin
        vista[0] = '0;
        for (int i = 1; i < 32; i++) begin
            vista[i] = regs_q[i];
        end
    end

    // Forwarding is suppressed during reset so reads show the reset contents.
    always_comb begin
        bypass1 = BYPASS && !reset && escrita_efetiva && (enderecoEscrita == enderecoLeitura1);
        bypass2 = BYPASS && !reset && escrita_efetiva && (enderecoEscrita == enderecoLeitura2);
    end

    // Read ports: write-first when forwarding applies, stored contents otherwise.
    always_comb begin
        dadoLeitura1 = bypass1 ? dadoEscrita : vista[enderecoLeitura1];
        dadoLeitura2 = bypass2 ? dadoEscrita : vista[enderecoLeitura2];
    end

    assign dadoDebug        = vista[enderecoDebug];
    assign contadorEscritas = contador_q;

endmodule

// File: tb/tb_banco_registradores.sv
// tb/tb_banco_registradores.sv - self-checking bench for banco_registradores
module tb_banco_registradores;

    localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
    localparam logic [31:0] GP_INIT = 32'h0000_1800;

    logic        clock;
    logic        reset;
    logic        regEscrita;
    logic [4:0]  enderecoEscrita;
    logic [31:0] dadoEscrita;
    logic [4:0]  enderecoLeitura1;
    logic [4:0]  enderecoLeitura2;
    logic [4:0]  enderecoDebug;

    logic [31:0] l1_b0, l2_b0, dbg_b0;
    logic [15:0] cnt_b0;
    logic [31:0] l1_b1, l2_b1, dbg_b1;
    logic [15:0] cnt_b1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_item_t;

    sb_item_t    sb_q [$];
    logic [31:0] modelo [32];

    banco_registradores #(
        .WIDTH(32), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT), .BYPASS(1'b0)
    ) dut_b0 (
        .clock(clock), .reset(reset), .regEscrita(regEscrita),
        .enderecoEscrita(enderecoEscrita), .dadoEscrita(dadoEscrita),
        .enderecoLeitura1(enderecoLeitura1), .enderecoLeitura2(enderecoLeitura2),
        .dadoLeitura1(l1_b0), .dadoLeitura2(l2_b0),
        .enderecoDebug(enderecoDebug), .dadoDebug(dbg_b0),
        .contadorEscritas(cnt_b0)
    );

    banco_registradores #(
        .WIDTH(32), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT), .BYPASS(1'b1)
    ) dut_b1 (
        .clock(clock), .reset(reset), .regEscrita(regEscrita),
        .enderecoEscrita(enderecoEscrita), .dadoEscrita(dadoEscrita),
        .enderecoLeitura1(enderecoLeitura1), .enderecoLeitura2(enderecoLeitura2),
        .dadoLeitura1(l1_b1), .dadoLeitura2(l2_b1),
        .enderecoDebug(enderecoDebug), .dadoDebug(dbg_b1),
        .contadorEscritas(cnt_b1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 32; i++) begin
            modelo[i] = 32'h0;
        end
        modelo[28] = GP_INIT;
        modelo[29] = SP_INIT;
    endtask

    // Queue the expected content of every register for a later debug-port sweep.
    task automatic sb_push_all();
        sb_item_t it;
        for (int i = 0; i < 32; i++) begin
            it.addr = 5'(i);
            it.data = modelo[i];
            sb_q.push_back(it);
        end
    endtask

    task automatic sb_drain(input string tag);
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            enderecoDebug = it.addr;
            #1;
            chk($sformatf("%s_b1_r%0d", tag, it.addr), dbg_b1, it.data);
            chk($sformatf("%s_b0_r%0d", tag, it.addr), dbg_b0, it.data);
        end
    endtask

    // One clocked write; the expected stored value is queued when driven.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        sb_item_t it;
        @(negedge clock);
        regEscrita      = 1'b1;
        enderecoEscrita = addr;
        dadoEscrita     = data;
        if (addr != 5'd0) begin
            modelo[addr] = data;
        end
        it.addr = addr;
        it.data = modelo[addr];
        sb_q.push_back(it);
        @(posedge clock);
        #1;
        regEscrita = 1'b0;
    endtask

    initial begin
        regEscrita       = 1'b0;
        enderecoEscrita  = 5'd0;
        dadoEscrita      = 32'h0;
        enderecoLeitura1 = 5'd0;
        enderecoLeitura2 = 5'd0;
        enderecoDebug    = 5'd0;
        reset            = 1'b0;
        #1;
        reset = 1'b1;
        modelo_reset();

        // Combinational reads reflect reset contents while reset is held.
        enderecoLeitura1 = 5'd29;
        enderecoLeitura2 = 5'd28;
        #1;
        chk("rst_hold_rd1_sp", l1_b1, SP_INIT);
        chk("rst_hold_rd2_gp", l2_b1, GP_INIT);
        chk("rst_hold_cnt", {16'h0, cnt_b1}, 32'h0);

        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        sb_push_all();
        sb_drain("rst");
        chk("rst_cnt_b1", {16'h0, cnt_b1}, 32'h0);
        chk("rst_cnt_b0", {16'h0, cnt_b0}, 32'h0);

        // Write register 5 and read it on both ports.
        enderecoLeitura1 = 5'd5;
        enderecoLeitura2 = 5'd5;
        do_write(5'd5, 32'hDEAD_BEEF);
        chk("w5_rd1_b1", l1_b1, 32'hDEAD_BEEF);
        chk("w5_rd2_b1", l2_b1, 32'hDEAD_BEEF);
        chk("w5_rd1_b0", l1_b0, 32'hDEAD_BEEF);
        chk("w5_rd2_b0", l2_b0, 32'hDEAD_BEEF);
        chk("w5_cnt", {16'h0, cnt_b1}, 32'h1);
        sb_drain("w5");

        // jal link: forwarded before the edge only when bypass is enabled.
        @(negedge clock);
        regEscrita       = 1'b1;
        enderecoEscrita  = 5'd31;
        dadoEscrita      = 32'h0040_0008;
        enderecoLeitura1 = 5'd31;
        enderecoLeitura2 = 5'd5;
        enderecoDebug    = 5'd31;
        modelo[31]       = 32'h0040_0008;
        #1;
        chk("jal_pre_rd1_b1", l1_b1, 32'h0040_0008);
        chk("jal_pre_rd1_b0", l1_b0, 32'h0);
        chk("jal_pre_rd2_b1", l2_b1, 32'hDEAD_BEEF);
        chk("jal_pre_dbg_b1", dbg_b1, 32'h0);
        @(posedge clock);
        #1;
        regEscrita = 1'b0;
        chk("jal_post_dbg_b1", dbg_b1, 32'h0040_0008);
        chk("jal_post_dbg_b0", dbg_b0, 32'h0040_0008);
        chk("jal_post_rd1_b0", l1_b0, 32'h0040_0008);
        chk("jal_cnt", {16'h0, cnt_b1}, 32'h2);

        // Both ports on the write target, each forwarded independently.
        @(negedge clock);
        regEscrita       = 1'b1;
        enderecoEscrita  = 5'd6;
        dadoEscrita      = 32'hA5A5_0F0F;
        enderecoLeitura1 = 5'd6;
        enderecoLeitura2 = 5'd6;
        modelo[6]        = 32'hA5A5_0F0F;
        #1;
        chk("dual_byp_rd1_b1", l1_b1, 32'hA5A5_0F0F);
        chk("dual_byp_rd2_b1", l2_b1, 32'hA5A5_0F0F);
        chk("dual_byp_rd2_b0", l2_b0, 32'h0);
        @(posedge clock);
        #1;
        regEscrita = 1'b0;
        chk("dual_cnt", {16'h0, cnt_b1}, 32'h3);

        // Write enable low: no forwarding and no state change.
        @(negedge clock);
        enderecoEscrita  = 5'd6;
        dadoEscrita      = 32'h1111_2222;
        #1;
        chk("we0_rd1_b1", l1_b1, 32'hA5A5_0F0F);
        @(posedge clock);
        #1;
        chk("we0_rd1_post", l1_b1, 32'hA5A5_0F0F);
        chk("we0_cnt", {16'h0, cnt_b1}, 32'h3);

        // Write to $zero is discarded, never forwarded, not counted.
        @(negedge clock);
        regEscrita       = 1'b1;
        enderecoEscrita  = 5'd0;
        dadoEscrita      = 32'hFFFF_FFFF;
        enderecoLeitura1 = 5'd0;
        enderecoLeitura2 = 5'd0;
        enderecoDebug    = 5'd0;
        #1;
        chk("z_pre_rd1_b1", l1_b1, 32'h0);
        chk("z_pre_rd2_b1", l2_b1, 32'h0);
        @(posedge clock);
        #1;
        regEscrita = 1'b0;
        chk("z_post_rd1_b1", l1_b1, 32'h0);
        chk("z_post_dbg_b1", dbg_b1, 32'h0);
        chk("z_cnt", {16'h0, cnt_b1}, 32'h3);

        // Asynchronous reset mid-cycle with a write pending to register 7.
        do_write(5'd7, 32'h0000_1234);
        sb_drain("w7");
        @(negedge clock);
        regEscrita       = 1'b1;
        enderecoEscrita  = 5'd7;
        dadoEscrita      = 32'h0000_AAAA;
        enderecoLeitura1 = 5'd7;
        enderecoDebug    = 5'd7;
        #2;
        reset = 1'b1;
        modelo_reset();
        #1;
        chk("arst_rd1_b1", l1_b1, 32'h0);
        chk("arst_dbg_b1", dbg_b1, 32'h0);
        chk("arst_cnt", {16'h0, cnt_b1}, 32'h0);
        @(posedge clock);
        #1;
        chk("arst_edge_dbg_b1", dbg_b1, 32'h0);
        chk("arst_edge_dbg_b0", dbg_b0, 32'h0);
        chk("arst_edge_cnt", {16'h0, cnt_b1}, 32'h0);
        @(negedge clock);
        regEscrita = 1'b0;
        reset      = 1'b0;
        #1;
        sb_push_all();
        sb_drain("arst");

        // Saturation of the write counter over 65537 effective writes.
        for (int n = 1; n <= 65537; n++) begin
            @(negedge clock);
            regEscrita      = 1'b1;
            enderecoEscrita = 5'((n % 31) + 1);
            dadoEscrita     = $urandom;
            modelo[enderecoEscrita] = dadoEscrita;
            @(posedge clock);
            #1;
            if (n == 65534) chk("sat_cnt_fffe", {16'h0, cnt_b1}, 32'h0000_FFFE);
            if (n == 65535) chk("sat_cnt_ffff", {16'h0, cnt_b1}, 32'h0000_FFFF);
        end
        regEscrita = 1'b0;
        chk("sat_hold_b1", {16'h0, cnt_b1}, 32'h0000_FFFF);
        chk("sat_hold_b0", {16'h0, cnt_b0}, 32'h0000_FFFF);
        sb_push_all();
        sb_drain("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
